// File: rtl/isa_bus_pkg.sv
// Shared types and constants for the ISA I/O cycle initiator.
package isa_bus_pkg;

  localparam int unsigned ISA_ADDR_W = 10;
  localparam int unsigned ISA_DATA_W = 8;

  localparam int unsigned DEF_T_SETUP      = 10;
  localparam int unsigned DEF_T_ALE_HOLD   = 24;
  localparam int unsigned DEF_T_STROBE     = 116;
  localparam int unsigned DEF_T_RECOVERY   = 10;
  localparam int unsigned DEF_WAIT_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    STROBE,
    WAIT,
    RELEASE,
    RECOVER
  } isa_state_e;

  // Largest of four phase lengths, used to size the shared phase counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/isa_phase_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module isa_phase_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  // Reload on phase entry, otherwise count down and stop at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!zero) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/isa_io_cycle_initiator.sv
// ISA I/O bus-cycle initiator: one read/write request in, one full
// ALE/AEN + IOR/IOW cycle out, one-clock response pulse back.
module isa_io_cycle_initiator
  import isa_bus_pkg::*;
#(
  parameter int unsigned T_SETUP      = DEF_T_SETUP,
  parameter int unsigned T_ALE_HOLD   = DEF_T_ALE_HOLD,
  parameter int unsigned T_STROBE     = DEF_T_STROBE,
  parameter int unsigned T_RECOVERY   = DEF_T_RECOVERY,
  parameter int unsigned WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ISA_ADDR_W-1:0] req_addr,
  input  logic [ISA_DATA_W-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [ISA_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ISA_ADDR_W-1:0] isa_address,
  output logic                  isa_ale,
  output logic                  isa_aen,
  output logic                  isa_ior,
  output logic                  isa_iow,
  output logic [ISA_DATA_W-1:0] isa_data_out,
  output logic                  isa_data_oe,
  input  logic [ISA_DATA_W-1:0] isa_data_in,
  input  logic                  isa_iochrdy
);

  localparam int unsigned CNT_MAX = max4(max4(T_STROBE, WAIT_TIMEOUT, T_SETUP, T_RECOVERY),
                                         0, 0, 0);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  // Counter is loaded with length-1 so that the zero flag marks the last
  // clock of a phase and the transition happens on the following edge.
  localparam cnt_t LD_SETUP    = cnt_t'(T_SETUP - 1);
  localparam cnt_t LD_STROBE   = cnt_t'(T_STROBE - 1);
  localparam cnt_t LD_WAIT     = cnt_t'(WAIT_TIMEOUT - 1);
  localparam cnt_t LD_RECOVERY = cnt_t'(T_RECOVERY - 1);
  // Counter value in STROBE at the edge where ALE/AEN must drop.
  localparam cnt_t ALE_DROP    = cnt_t'(T_STROBE - T_ALE_HOLD);

  isa_state_e state;
  logic       wr_q;

  logic       cnt_load;
  cnt_t       cnt_value;
  cnt_t       cnt_count;
  logic       cnt_zero;

  logic       accept;
  logic       release_now;
  logic       release_tmo;

  assign accept      = (state == IDLE) && req_valid && req_ready;
  assign release_now = ((state == STROBE) && cnt_zero && isa_iochrdy) ||
                       ((state == WAIT) && (isa_iochrdy || cnt_zero));
  assign release_tmo = (state == WAIT) && !isa_iochrdy && cnt_zero;

  isa_phase_counter #(
    .WIDTH(CNT_W)
  ) u_phase_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (cnt_load),
    .load_value(cnt_value),
    .count     (cnt_count),
    .zero      (cnt_zero)
  );

  // Reload the phase counter on every state entry that has a timed phase.
  always_comb begin
    cnt_load  = 1'b0;
    cnt_value = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_load  = 1'b1;
          cnt_value = LD_SETUP;
        end
      end
      ADDR: begin
        if (cnt_zero) begin
          cnt_load  = 1'b1;
          cnt_value = LD_STROBE;
        end
      end
      STROBE: begin
        if (cnt_zero && !isa_iochrdy) begin
          cnt_load  = 1'b1;
          cnt_value = LD_WAIT;
        end
      end
      RELEASE: begin
        cnt_load  = 1'b1;
        cnt_value = LD_RECOVERY;
      end
      default: begin
      end
    endcase
  end

  // Cycle FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      req_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_timeout  <= 1'b0;
      isa_address  <= '0;
      isa_ale      <= 1'b0;
      isa_aen      <= 1'b0;
      isa_ior      <= 1'b1;
      isa_iow      <= 1'b1;
      isa_data_out <= '0;
      isa_data_oe  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            wr_q        <= req_write;
            isa_address <= req_addr;
            if (req_write) isa_data_out <= req_wdata;
            isa_ale     <= 1'b1;
            isa_aen     <= 1'b1;
            isa_data_oe <= req_write;
            req_ready   <= 1'b0;
            state       <= ADDR;
          end else begin
            req_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (cnt_zero) begin
            isa_ior <= wr_q;
            isa_iow <= !wr_q;
            if (T_ALE_HOLD == 0) begin
              isa_ale <= 1'b0;
              isa_aen <= 1'b0;
            end
            state <= STROBE;
          end
        end
        STROBE: begin
          if (cnt_count == ALE_DROP) begin
            isa_ale <= 1'b0;
            isa_aen <= 1'b0;
          end
          if (cnt_zero) state <= isa_iochrdy ? RELEASE : WAIT;
        end
        WAIT: begin
          if (release_now) state <= RELEASE;
        end
        RELEASE: begin
          isa_data_oe <= 1'b0;
          state       <= RECOVER;
        end
        RECOVER: begin
          if (cnt_zero) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Strobe release, read capture and response share one edge.
      if (release_now) begin
        isa_ior     <= 1'b1;
        isa_iow     <= 1'b1;
        rsp_valid   <= 1'b1;
        rsp_timeout <= release_tmo;
        if (!wr_q) rsp_rdata <= isa_data_in;
      end
    end
  end

endmodule

// File: tb/tb_isa_io_cycle_initiator.sv
// Directed self-checking bench for isa_io_cycle_initiator (default timing).
module tb_isa_io_cycle_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic [9:0] isa_address;
  logic       isa_ale;
  logic       isa_aen;
  logic       isa_ior;
  logic       isa_iow;
  logic [7:0] isa_data_out;
  logic       isa_data_oe;
  logic [7:0] isa_data_in;
  logic       isa_iochrdy;

  always #5 clk = ~clk;

  isa_io_cycle_initiator #(
    .T_SETUP     (10),
    .T_ALE_HOLD  (24),
    .T_STROBE    (116),
    .T_RECOVERY  (10),
    .WAIT_TIMEOUT(255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .isa_address (isa_address),
    .isa_ale     (isa_ale),
    .isa_aen     (isa_aen),
    .isa_ior     (isa_ior),
    .isa_iow     (isa_iow),
    .isa_data_out(isa_data_out),
    .isa_data_oe (isa_data_oe),
    .isa_data_in (isa_data_in),
    .isa_iochrdy (isa_iochrdy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Per-cycle observations, indexed by t = clocks since the accept edge.
  int unsigned ale_n, aen_n, ior_n, iow_n, oe_n, rsp_n;
  int unsigned rsp_t, ior_first, ready_t, rise1_t, rise2_t;
  int unsigned addr_bad, dout_bad, rdata_seen, tmo_seen, addr2_seen;
  logic        prev_ale;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic wait_ready();
    int unsigned waited = 0;
    while (!req_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    check("req_ready_wait", int'(req_ready), 1);
  endtask

  // Issue one request and sample every negedge for tmax clocks.
  // iochrdy is low for t in [low_from, low_from+low_len).
  task automatic run_cycle(input logic wr, input logic [9:0] addr, input logic [7:0] wd,
                           input logic keep_valid, input logic [9:0] addr2,
                           input int unsigned low_from, input int unsigned low_len,
                           input int unsigned tmax);
    ale_n = 0; aen_n = 0; ior_n = 0; iow_n = 0; oe_n = 0; rsp_n = 0;
    rsp_t = 0; ior_first = 0; ready_t = 0; rise1_t = 0; rise2_t = 0;
    addr_bad = 0; dout_bad = 0; rdata_seen = 0; tmo_seen = 0; addr2_seen = 0;
    wait_ready();
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    prev_ale  = isa_ale;
    for (int unsigned t = 1; t <= tmax; t++) begin
      @(negedge clk);
      if (t == 1) begin
        if (keep_valid) req_addr = addr2;
        else req_valid = 1'b0;
      end
      isa_iochrdy = (t >= low_from && t < low_from + low_len) ? 1'b0 : 1'b1;
      if (isa_ale && !prev_ale) begin
        if (rise1_t == 0) rise1_t = t;
        else if (rise2_t == 0) begin
          rise2_t    = t;
          addr2_seen = isa_address;
        end
      end
      prev_ale = isa_ale;
      if (ready_t == 0) begin
        if (req_ready) ready_t = t;
        else begin
          if (isa_ale) ale_n++;
          if (isa_aen) aen_n++;
          if (!isa_ior) ior_n++;
          if (!isa_iow) iow_n++;
          if (isa_data_oe) oe_n++;
          if (!isa_ior && ior_first == 0) ior_first = t;
          if (isa_address != addr) addr_bad++;
          if (wr && isa_data_oe && isa_data_out != wd) dout_bad++;
          if (rsp_valid) begin
            rsp_n++;
            if (rsp_t == 0) begin
              rsp_t      = t;
              rdata_seen = rsp_rdata;
              tmo_seen   = rsp_timeout;
            end
          end
        end
      end
    end
    req_valid   = 1'b0;
    isa_iochrdy = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rsp_after, ior_after;
    rst_n       = 1'b0;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_addr    = 10'h3FF;
    req_wdata   = 8'hFF;
    isa_data_in = 8'hA5;
    isa_iochrdy = 1'b1;

    // Reset values, with a request pending that must be ignored.
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_ior", int'(isa_ior), 1);
    check("rst_iow", int'(isa_iow), 1);
    check("rst_ale", int'(isa_ale), 0);
    check("rst_aen", int'(isa_aen), 0);
    check("rst_address", isa_address, 0);
    check("rst_data_out", isa_data_out, 0);
    check("rst_data_oe", int'(isa_data_oe), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_timeout", int'(rsp_timeout), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready_after", int'(req_ready), 1);
    check("rst_valid_ignored_ale", int'(isa_ale), 0);
    req_valid = 1'b0;
    @(negedge clk);

    // Plain read.
    run_cycle(1'b0, 10'h100, 8'h00, 1'b0, 10'h000, 0, 0, 140);
    check("rd_ale_high", ale_n, 34);
    check("rd_aen_high", aen_n, 34);
    check("rd_ale_rise", rise1_t, 1);
    check("rd_ior_first", ior_first, 11);
    check("rd_ior_low", ior_n, 116);
    check("rd_iow_low", iow_n, 0);
    check("rd_data_oe", oe_n, 0);
    check("rd_addr_held", addr_bad, 0);
    check("rd_rsp_t", rsp_t, 127);
    check("rd_rsp_n", rsp_n, 1);
    check("rd_rdata", rdata_seen, 8'hA5);
    check("rd_timeout", tmo_seen, 0);
    check("rd_ready_t", ready_t, 138);

    // Write: read data register must keep 0xA5.
    isa_data_in = 8'h11;
    run_cycle(1'b1, 10'h13E, 8'h5A, 1'b0, 10'h000, 0, 0, 140);
    check("wr_iow_low", iow_n, 116);
    check("wr_ior_low", ior_n, 0);
    check("wr_data_oe", oe_n, 127);
    check("wr_data_out", dout_bad, 0);
    check("wr_data_out_val", isa_data_out, 8'h5A);
    check("wr_addr_held", addr_bad, 0);
    check("wr_rsp_t", rsp_t, 127);
    check("wr_rdata_kept", rdata_seen, 8'hA5);
    check("wr_timeout", tmo_seen, 0);

    // Read stretched by 20 iochrdy-low clocks.
    isa_data_in = 8'h3C;
    run_cycle(1'b0, 10'h2C1, 8'h00, 1'b0, 10'h000, 126, 20, 160);
    check("wt_ior_low", ior_n, 136);
    check("wt_rsp_t", rsp_t, 147);
    check("wt_rdata", rdata_seen, 8'h3C);
    check("wt_timeout", tmo_seen, 0);
    check("wt_ready_t", ready_t, 158);

    // Read with iochrdy stuck low: timeout.
    isa_data_in = 8'hC3;
    run_cycle(1'b0, 10'h055, 8'h00, 1'b0, 10'h000, 126, 1000, 395);
    check("to_ior_low", ior_n, 371);
    check("to_rsp_t", rsp_t, 382);
    check("to_rsp_n", rsp_n, 1);
    check("to_rdata", rdata_seen, 8'hC3);
    check("to_timeout", tmo_seen, 1);
    check("to_ready_t", ready_t, 393);

    // Back-to-back with valid held.
    isa_data_in = 8'hA5;
    run_cycle(1'b0, 10'h100, 8'h00, 1'b1, 10'h101, 0, 0, 140);
    check("b2b_rise1", rise1_t, 1);
    check("b2b_rise2", rise2_t, 139);
    check("b2b_addr2", addr2_seen, 10'h101);
    check("b2b_ready_t", ready_t, 138);

    // Reset in the middle of STROBE.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 10'h155;
    for (int unsigned t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (t == 1) req_valid = 1'b0;
    end
    check("mr_pre_ior", int'(isa_ior), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_ior", int'(isa_ior), 1);
    check("mr_iow", int'(isa_iow), 1);
    check("mr_ale", int'(isa_ale), 0);
    check("mr_aen", int'(isa_aen), 0);
    check("mr_data_oe", int'(isa_data_oe), 0);
    check("mr_rsp_valid", int'(rsp_valid), 0);
    check("mr_req_ready", int'(req_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_ready_after", int'(req_ready), 1);
    rsp_after = 0;
    ior_after = 0;
    for (int unsigned t = 0; t < 150; t++) begin
      @(negedge clk);
      if (rsp_valid) rsp_after++;
      if (!isa_ior) ior_after++;
    end
    check("mr_no_rsp", rsp_after, 0);
    check("mr_no_strobe", ior_after, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
